fdiv_sched: RTL
===============

FDIV_SCHED -- requirements
Module: fdiv_sched

Interface
REQ-001 SHALL have parameter DIV_TIMEOUT, default 15: the maximum number of WAIT cycles allowed before a divide is aborted.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have ports req_valid[1:0] (input, 2) and req_ready[1:0] (output, 2): the per-requester request handshake.
REQ-005 SHALL have ports req_x1_0, req_x2_0, req_x1_1, req_x2_1 (input, 32 each): the dividend and divisor for requesters 0 and 1.
REQ-006 SHALL have ports resp_valid[1:0] (output, 2) and resp_ready[1:0] (input, 2): the per-requester response handshake.
REQ-007 SHALL have port resp_data (output, 32): the quotient, meaningful for whichever resp_valid bit is high.
REQ-008 SHALL have port resp_err (output, 1): high with resp_valid when the response came from a timeout.
REQ-009 SHALL have ports div_x1 and div_x2 (output, 32 each): operands to the shared divider.
REQ-010 SHALL have port div_en (output, 1): the divider start strobe.
REQ-011 SHALL have port div_y (input, 32): the divider result.
REQ-012 SHALL have ports div_valid (input, 1, result strobe) and div_idle (input, 1, divider ready).

Function
REQ-013 SHALL implement a state machine with states IDLE, ISSUE, WAIT and RESP.
REQ-014 In IDLE, req_ready[i] SHALL equal grant[i] AND div_idle; at most one req_ready bit is high per cycle.
REQ-015 Arbitration SHALL be round-robin.
- Single requester: that requester is granted.
- Both requesting: grant goes to the port not served last; the pointer resets to favour port 0.
REQ-016 On IDLE with req_valid[i] & req_ready[i], the block SHALL:
- latch x1, x2 and owner=i;
- update the round-robin pointer;
- go to ISSUE.
REQ-017 ISSUE SHALL last exactly one cycle, in which:
- div_en=1;
- div_x1/div_x2 = the latched operands;
- the next state is WAIT with the timeout counter cleared.
REQ-018 div_x1/div_x2 SHALL hold the latched operands in all states; div_en SHALL be 0 outside ISSUE.
REQ-019 In WAIT, the 4-bit minimum counter SHALL increment each cycle. On div_valid=1, the block SHALL capture div_y into the result register, clear err and go to RESP.
REQ-020 If the counter reaches DIV_TIMEOUT without div_valid, the block SHALL load result=32'h0 and err=1, then go to RESP.
REQ-021 div_valid arriving outside WAIT SHALL be ignored.
- Covers stale pulses after reset or timeout.
- Captured data and state are unchanged.
REQ-022 In RESP, resp_valid[owner]=1, resp_data=result and resp_err=err SHALL be held stable until resp_ready[owner]=1; the handshake cycle then returns to IDLE.
REQ-023 resp_valid SHALL be registered, and at most one bit SHALL be high at a time.
REQ-024 Response latency SHALL be:
- resp_valid high the cycle after div_valid is sampled;
- minimum 3 cycles from acceptance to resp_valid, plus the divider latency.
REQ-025 While not in IDLE, req_ready SHALL be 2'b00; requests stay pending on their own handshake. There is no queueing beyond one in-flight operation.
REQ-026 If div_idle=0 in IDLE, no grant SHALL be issued; the arbitration pointer is unchanged.
REQ-027 Requester operands SHALL be sampled only in the acceptance cycle; later changes have no effect.

Reset
REQ-028 On rstn=0, the block SHALL asynchronously set:
- state=IDLE, pointer=port 0;
- req_ready=0, resp_valid=0, resp_data=0, resp_err=0;
- div_en=0, div_x1=div_x2=0;
- counter=0.
REQ-029 Reset mid-operation SHALL abandon the in-flight divide with no response; the first post-reset grant waits for div_idle=1.
REQ-030 Reset deassertion SHALL be synchronised before use, and the first state change SHALL occur no earlier than the second clk edge after rstn rises.

Verification
REQ-031 Port 0 requests 0x3F800000/0x40000000 with a 5-cycle divider model -> resp_valid[0] with resp_data≈0x3F000000, resp_err=0, div_en exactly one cycle.
REQ-032 Both ports request in the same cycle after reset -> port 0 is served, then port 1 (0x40400000/0x3F800000 -> ≈0x40400000); on the next simultaneous request, port 0 is served first again.
REQ-033 Divider model never asserts div_valid -> after DIV_TIMEOUT WAIT cycles, resp_valid[owner]=1, resp_data=0, resp_err=1; a late div_valid is then ignored.
REQ-034 resp_ready held 0 for 10 cycles -> resp_valid and resp_data stay stable, req_ready stays 0, and a new request is accepted only after the handshake completes.
REQ-035 rstn pulsed low during WAIT -> all outputs are 0 immediately, no response is issued, the stale div_valid is ignored, and the next request completes normally.
REQ-036 div_idle held 0 with req_valid=2'b11 -> no req_ready and no div_en until div_idle rises.

Source files
------------

// File: rtl/fdiv_sched.sv
// fdiv_sched: arbitrates two requesters onto one shared floating-point divider.
// One divide is in flight at a time. A divide that never returns is aborted
// after DIV_TIMEOUT wait cycles and answered with a zero quotient and an error flag.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | offer a round-robin grant while the divider reports idle
// ISSUE | one-cycle start strobe to the divider with the latched operands
// WAIT  | count cycles until the divider result strobe or the timeout
// RESP  | hold the response to the owner until it handshakes
module fdiv_sched #(
    parameter int DIV_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_x1_0,
    input  logic [31:0] req_x2_0,
    input  logic [31:0] req_x1_1,
    input  logic [31:0] req_x2_1,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] div_x1,
    output logic [31:0] div_x2,
    output logic        div_en,
    input  logic [31:0] div_y,
    input  logic        div_valid,
    input  logic        div_idle
);

    // Counter is at least 4 bits and wide enough to hold DIV_TIMEOUT.
    localparam int CNT_W = (DIV_TIMEOUT < 16) ? 4 : $clog2(DIV_TIMEOUT + 1);
    // Last WAIT cycle index before the timeout fires.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       rst_sync;
    logic             run;
    logic             rr_ptr;      // 1: port 1 wins a tie, 0: port 0 wins a tie
    logic             owner;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      result;
    logic             err;
    logic [1:0]       grant;
    logic             accept;
    logic             acc_port;
    logic             owner_ready;

    // Reset release is re-timed to clk; nothing moves until both stages are set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    // Round-robin grant: a lone requester always wins, a tie goes to rr_ptr.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready   = (run && (state == IDLE) && div_idle) ? grant : 2'b00;
    assign accept      = |(req_valid & req_ready);
    assign acc_port    = req_ready[1];
    assign owner_ready = owner ? resp_ready[1] : resp_ready[0];

    assign resp_data   = result;
    assign resp_err    = err;

    // Sequencing FSM with registered handshake and strobe outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            owner      <= 1'b0;
            div_en     <= 1'b0;
            resp_valid <= 2'b00;
            wait_cnt   <= '0;
        end else if (run) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner  <= acc_port;
                        rr_ptr <= ~acc_port;
                        div_en <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    div_en   <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (div_valid || (wait_cnt == CNT_LAST)) begin
                        resp_valid <= {owner, ~owner};
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (owner_ready) begin
                        resp_valid <= 2'b00;
                        state      <= IDLE;
                    end
                end
                default: begin
                    div_en     <= 1'b0;
                    resp_valid <= 2'b00;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Operands are captured only in the acceptance cycle and driven to the divider from then on.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_x1 <= 32'h0;
            div_x2 <= 32'h0;
        end else if (run && (state == IDLE) && accept) begin
            div_x1 <= acc_port ? req_x1_1 : req_x1_0;
            div_x2 <= acc_port ? req_x2_1 : req_x2_0;
        end
    end

    // Result register: divider quotient on the strobe, zero plus error on timeout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result <= 32'h0;
            err    <= 1'b0;
        end else if (run && (state == WAIT)) begin
            if (div_valid) begin
                result <= div_y;
                err    <= 1'b0;
            end else if (wait_cnt == CNT_LAST) begin
                result <= 32'h0;
                err    <= 1'b1;
            end
        end
    end

endmodule
